// File: rtl/ofifo_pkg.sv
// ofifo_pkg
//   Shared definitions for the parametrised output FIFO and its testbench.
//   - Default geometry (lanes, lane width, depth, almost-full watermark).
//   - ptr_w(depth): read/write pointer width for a lane of `depth` entries.
//   - cnt_w(depth): occupancy counter width (one bit wider than a pointer so
//     that the value `depth` itself is representable).
//   - lane_lo(lane, bw): low bit of lane `lane` inside a packed row.
package ofifo_pkg;

  localparam int COL_DEF       = 8;
  localparam int BW_DEF        = 16;
  localparam int DEPTH_DEF     = 64;
  localparam int AF_THRESH_DEF = 56;

  // A depth of 1 would give a zero-width pointer; the block requires depth >= 2,
  // the guard only keeps the function total.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  function automatic int lane_lo(input int lane, input int bw);
    return lane * bw;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// ofifo_lane
//   One lane of the output FIFO: a bw-wide, depth-deep circular buffer.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-low reset (pointers and count cleared)
//     push   store din at the write pointer (caller guarantees !full | pop)
//     pop    advance the read pointer (caller guarantees !empty)
//     din    write data
//     dout   head entry (combinational read of the read pointer)
//     full   count == depth
//     empty  count == 0
//     count  current occupancy, 0..depth
//   Pointers wrap naturally modulo depth (depth is a power of two).
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int bw    = 16,
  parameter int depth = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [bw-1:0]           din,
  output logic [bw-1:0]           dout,
  output logic                    full,
  output logic                    empty,
  output logic [cnt_w(depth)-1:0] count
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);

  logic [bw-1:0] mem [depth];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;

  // Storage is not reset: contents are unreachable until the count says so.
  // When full with a simultaneous pop, wr_ptr == rd_ptr; the old head has
  // already been presented on dout for this edge, so overwriting it is safe.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Push and pop together leave the occupancy unchanged.
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(depth));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/ofifo_param.sv
// ofifo_param
//   Output FIFO between the systolic array's per-column accumulators and the
//   SRAM write-back path. Each of `col` lanes is written independently as its
//   column finishes; rows are popped from all lanes at once.
//   Ports:
//     clk            rising-edge clock
//     reset          synchronous active-low reset
//     in             write data, lane i at [i*bw +: bw]
//     wr             per-lane write strobe
//     rd             pop-row request
//     clr_err        clears o_overflow and o_underflow (set wins)
//     out            registered popped row, lane i at [i*bw +: bw]
//     o_full         some lane holds depth entries
//     o_ready        !o_full
//     o_valid        every lane holds at least one entry
//     o_almost_full  some lane holds >= af_thresh entries
//     o_count        minimum lane occupancy = number of complete rows
//     o_overflow     sticky: a write was dropped
//     o_underflow    sticky: a read was refused
//
//   Handshake: a row transfers out when rd && o_valid at a rising edge, and
//   the row appears on `out` after that edge, held until the next pop. A
//   lane write transfers when wr[i] && (lane not full || a pop happens in the
//   same cycle); otherwise it is dropped and flagged. o_valid/o_ready/o_full
//   depend only on registered lane counts, never on rd or wr in the same
//   cycle, so a write at an edge is visible in status only after that edge.
module ofifo_param
  import ofifo_pkg::*;
#(
  parameter int col       = COL_DEF,
  parameter int bw        = BW_DEF,
  parameter int depth     = DEPTH_DEF,
  parameter int af_thresh = AF_THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [col*bw-1:0]       in,
  input  logic [col-1:0]          wr,
  input  logic                    rd,
  input  logic                    clr_err,
  output logic [col*bw-1:0]       out,
  output logic                    o_full,
  output logic                    o_ready,
  output logic                    o_valid,
  output logic                    o_almost_full,
  output logic [cnt_w(depth)-1:0] o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int CW = cnt_w(depth);

  logic [col-1:0] lane_full;
  logic [col-1:0] lane_empty;
  logic [col-1:0] push;
  logic [CW-1:0]  lane_cnt  [col];
  logic [bw-1:0]  lane_din  [col];
  logic [bw-1:0]  lane_dout [col];
  logic [col*bw-1:0] head_row;

  logic          pop;
  logic          drop;
  logic          refuse;
  logic [CW-1:0] min_cnt;
  logic          any_af;

  // Lane slicing of the packed write bus and packing of the head row.
  always_comb begin
    head_row = '0;
    for (int i = 0; i < col; i++) begin
      lane_din[i] = in[lane_lo(i, bw) +: bw];
      head_row[lane_lo(i, bw) +: bw] = lane_dout[i];
    end
  end

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(
      .bw    (bw),
      .depth (depth)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .push  (push[g]),
      .pop   (pop),
      .din   (lane_din[g]),
      .dout  (lane_dout[g]),
      .full  (lane_full[g]),
      .empty (lane_empty[g]),
      .count (lane_cnt[g])
    );
  end

  // Min reduction gives the number of complete rows; the watermark only needs
  // to know whether any lane has reached it (equivalent to max >= af_thresh).
  always_comb begin
    min_cnt = lane_cnt[0];
    any_af  = 1'b0;
    for (int i = 0; i < col; i++) begin
      if (lane_cnt[i] < min_cnt) begin
        min_cnt = lane_cnt[i];
      end
      if (lane_cnt[i] >= CW'(af_thresh)) begin
        any_af = 1'b1;
      end
    end
  end

  assign o_full        = |lane_full;
  assign o_ready       = !o_full;
  assign o_valid       = !(|lane_empty);
  assign o_almost_full = any_af;
  assign o_count       = min_cnt;

  // Qualification uses pre-edge counts only: a push into an empty lane in the
  // same cycle as rd cannot make that rd succeed.
  assign pop    = rd && o_valid;
  assign push   = wr & (~lane_full | {col{pop}});
  assign drop   = (|(wr & lane_full)) && !pop;
  assign refuse = rd && !o_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      // New events override a simultaneous clear.
      o_overflow  <= (o_overflow  && !clr_err) || drop;
      o_underflow <= (o_underflow && !clr_err) || refuse;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out <= '0;
    end else if (pop) begin
      out <= head_row;
    end
  end

endmodule

// File: tb/tb_ofifo_param.sv
// tb_ofifo_param
//   Self-checking bench for ofifo_param. The reference model keeps one queue
//   per lane and predicts popped rows into exp_q; scenario tasks compare DUT
//   outputs against it inline.
module tb_ofifo_param;
  import ofifo_pkg::*;

  localparam int COL   = COL_DEF;
  localparam int BW    = BW_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int AF    = AF_THRESH_DEF;
  localparam int CW    = cnt_w(DEPTH);
  localparam int W     = COL * BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [W-1:0]   din;
  logic [COL-1:0] wr;
  logic           rd;
  logic           clr_err;
  logic [W-1:0]   dout;
  logic           o_full, o_ready, o_valid, o_almost_full;
  logic [CW-1:0]  o_count;
  logic           o_overflow, o_underflow;

  ofifo_param #(
    .col (COL), .bw (BW), .depth (DEPTH), .af_thresh (AF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in            (din),
    .wr            (wr),
    .rd            (rd),
    .clr_err       (clr_err),
    .out           (dout),
    .o_full        (o_full),
    .o_ready       (o_ready),
    .o_valid       (o_valid),
    .o_almost_full (o_almost_full),
    .o_count       (o_count),
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [BW-1:0] lq [COL][$];
  logic [W-1:0]  exp_q [$];
  logic          m_ovf;
  logic          m_unf;
  bit            popped;
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic int m_min();
    int m = lq[0].size();
    for (int i = 1; i < COL; i++) if (lq[i].size() < m) m = lq[i].size();
    return m;
  endfunction

  function automatic bit m_any_full();
    bit f = 0;
    for (int i = 0; i < COL; i++) if (lq[i].size() == DEPTH) f = 1;
    return f;
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = BW'($urandom);
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    wr = '1; rd = 1'b1; clr_err = 1'b0; din = rand_row();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; wr = '0; rd = 1'b0;
    for (int i = 0; i < COL; i++) lq[i].delete();
    exp_q.delete();
    m_ovf = 0; m_unf = 0; popped = 0;
  endtask

  // One clock: drive inputs, advance the model by the FIFO's rules, then let
  // the edge happen and return 1 time unit after it.
  task automatic cycle(input logic [COL-1:0] w, input logic r, input logic c,
                       input logic [W-1:0] d);
    int           mn;
    bit           ovf_set;
    bit           full_i;
    logic [W-1:0] row;
    wr = w; rd = r; clr_err = c; din = d;
    mn = m_min();
    popped = r && (mn > 0);
    ovf_set = 0;
    row = '0;
    for (int i = 0; i < COL; i++) begin
      full_i = (lq[i].size() == DEPTH);
      if (popped) row[i*BW +: BW] = lq[i].pop_front();
      if (w[i]) begin
        if (!full_i || popped) lq[i].push_back(d[i*BW +: BW]);
        else ovf_set = 1;
      end
    end
    if (popped) exp_q.push_back(row);
    m_ovf = (m_ovf && !c) || ovf_set;
    m_unf = (m_unf && !c) || (r && mn == 0);
    @(posedge clk); #1;
    wr = '0; rd = 1'b0; clr_err = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    apply_reset();
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", o_ready); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    n_checks++; if (o_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", o_count); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_out: got %h want 0", dout); end
    n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
    n_checks++; if (o_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af: got %b want 0", o_almost_full); end
    n_checks++; if ({o_overflow, o_underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b want 00", o_overflow, o_underflow); end
  endtask

  task automatic test_staggered();
    logic [W-1:0] first;
    logic [W-1:0] e;
    apply_reset();
    first = rand_row();
    cycle(8'h01, 0, 0, first);
    cycle(8'h01, 0, 0, rand_row());
    cycle(8'h01, 0, 0, rand_row());
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stag_valid0: got %b want 0", o_valid); end
    n_checks++; if (o_count !== CW'(0)) begin n_fail++; $display("FAIL stag_count0: got %0d want 0", o_count); end
    cycle(8'hFE, 0, 0, rand_row());
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stag_valid1: got %b want 1", o_valid); end
    n_checks++; if (o_count !== CW'(1)) begin n_fail++; $display("FAIL stag_count1: got %0d want 1", o_count); end
    cycle('0, 1, 0, '0);
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++; if (!popped || dout !== e) begin n_fail++; $display("FAIL stag_row: got %h want %h", dout, e); end
    n_checks++; if (dout[BW-1:0] !== first[BW-1:0]) begin n_fail++; $display("FAIL stag_lane0: got %h want %h", dout[BW-1:0], first[BW-1:0]); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL stag_valid_after: got %b want 0", o_valid); end
  endtask

  task automatic test_fill_wrap();
    logic [W-1:0] e;
    int pops;
    int guard;
    logic [COL-1:0] w;
    apply_reset();
    for (int k = 1; k <= DEPTH; k++) begin
      cycle('1, 0, 0, rand_row());
      n_checks++; if (o_count !== CW'(k)) begin n_fail++; $display("FAIL fill_count: got %0d want %0d", o_count, k); end
      n_checks++; if (o_almost_full !== (k >= AF)) begin n_fail++; $display("FAIL fill_af at %0d: got %b want %b", k, o_almost_full, (k >= AF)); end
    end
    n_checks++; if ({o_full, o_ready} !== 2'b10) begin n_fail++; $display("FAIL fill_full: got full=%b ready=%b want 1/0", o_full, o_ready); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL fill_ovf0: got %b want 0", o_overflow); end
    cycle('1, 0, 0, rand_row());
    n_checks++; if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL drop_ovf: got %b want 1", o_overflow); end
    n_checks++; if (o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL drop_count: got %0d want %0d", o_count, DEPTH); end
    cycle('0, 0, 1, '0);
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", o_overflow); end
    for (int k = 0; k < DEPTH; k++) begin
      cycle('0, 1, 0, '0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++; if (!popped || dout !== e) begin n_fail++; $display("FAIL drain_row %0d: got %h want %h", k, dout, e); end
    end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", o_valid); end
    // Mixed random traffic across pointer wrap, bounded by a cycle budget.
    pops = 0; guard = 0;
    while (pops < 100 && guard < 2000) begin
      guard++;
      w = ($urandom_range(0, 3) != 0) ? '1 : COL'($urandom);
      cycle(w, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, rand_row());
      if (popped) begin
        pops++;
        e = exp_q.pop_front();
        n_checks++; if (dout !== e) begin n_fail++; $display("FAIL wrap_row: got %h want %h", dout, e); end
      end
      n_checks++; if (o_count !== CW'(m_min())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", o_count, m_min()); end
      n_checks++; if (o_full !== m_any_full()) begin n_fail++; $display("FAIL wrap_full: got %b want %b", o_full, m_any_full()); end
      n_checks++; if ({o_overflow, o_underflow} !== {m_ovf, m_unf}) begin n_fail++; $display("FAIL wrap_flags: got %b%b want %b%b", o_overflow, o_underflow, m_ovf, m_unf); end
    end
    n_checks++; if (pops < 100) begin n_fail++; $display("FAIL wrap_budget: got %0d pops want 100", pops); end
  endtask

  task automatic test_push_full_pop();
    logic [W-1:0] nrow;
    logic [W-1:0] e;
    apply_reset();
    for (int k = 0; k < DEPTH; k++) cycle('1, 0, 0, rand_row());
    nrow = rand_row();
    cycle('1, 1, 0, nrow);
    n_checks++; if (o_count !== CW'(DEPTH)) begin n_fail++; $display("FAIL pfp_count: got %0d want %0d", o_count, DEPTH); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL pfp_ovf: got %b want 0", o_overflow); end
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    n_checks++; if (!popped || dout !== e) begin n_fail++; $display("FAIL pfp_first: got %h want %h", dout, e); end
    for (int k = 0; k < DEPTH; k++) begin
      cycle('0, 1, 0, '0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++; if (!popped || dout !== e) begin n_fail++; $display("FAIL pfp_drain %0d: got %h want %h", k, dout, e); end
    end
    n_checks++; if (dout !== nrow) begin n_fail++; $display("FAIL pfp_last: got %h want %h", dout, nrow); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL pfp_empty: got %b want 0", o_valid); end
  endtask

  task automatic test_underflow();
    logic [W-1:0] r0;
    apply_reset();
    r0 = rand_row();
    cycle('1, 0, 0, r0);
    cycle('0, 1, 0, '0);
    void'(exp_q.pop_front());
    n_checks++; if (dout !== r0) begin n_fail++; $display("FAIL unf_pop: got %h want %h", dout, r0); end
    cycle('0, 1, 0, '0);
    n_checks++; if (dout !== r0) begin n_fail++; $display("FAIL unf_out_hold: got %h want %h", dout, r0); end
    n_checks++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set: got %b want 1", o_underflow); end
    cycle('0, 0, 1, '0);
    n_checks++; if (o_underflow !== 1'b0) begin n_fail++; $display("FAIL unf_clr: got %b want 0", o_underflow); end
    cycle('0, 1, 1, '0);
    n_checks++; if (o_underflow !== 1'b1) begin n_fail++; $display("FAIL unf_set_wins: got %b want 1", o_underflow); end
    n_checks++; if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL unf_ovf: got %b want 0", o_overflow); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] e;
    logic [W-1:0] r;
    apply_reset();
    for (int k = 0; k < 10; k++) cycle('1, 0, 0, rand_row());
    for (int k = 0; k < 3; k++) begin
      cycle('0, 1, 0, '0);
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      n_checks++; if (!popped || dout !== e) begin n_fail++; $display("FAIL mid_pre_row: got %h want %h", dout, e); end
    end
    apply_reset();
    n_checks++; if (o_count !== '0) begin n_fail++; $display("FAIL mid_count: got %0d want 0", o_count); end
    n_checks++; if ({o_valid, o_ready, o_full, o_almost_full} !== 4'b0100) begin n_fail++; $display("FAIL mid_status: got %b want 0100", {o_valid, o_ready, o_full, o_almost_full}); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL mid_out: got %h want 0", dout); end
    n_checks++; if ({o_overflow, o_underflow} !== 2'b00) begin n_fail++; $display("FAIL mid_flags: got %b%b want 00", o_overflow, o_underflow); end
    r = rand_row();
    cycle('1, 0, 0, r);
    n_checks++; if (o_count !== CW'(1)) begin n_fail++; $display("FAIL mid_rt_count: got %0d want 1", o_count); end
    cycle('0, 1, 0, '0);
    n_checks++; if (dout !== r) begin n_fail++; $display("FAIL mid_rt_row: got %h want %h", dout, r); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b0; wr = '0; rd = 1'b0; clr_err = 1'b0; din = '0;
    m_ovf = 0; m_unf = 0; popped = 0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_staggered();
    test_fill_wrap();
    test_push_full_pop();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ofifo_param.md
# ofifo_param

Parametrised output FIFO placed between the systolic array's per-column accumulator outputs and the SRAM write-back path. Each of `col` lanes accepts writes independently as its column finishes. Rows are popped all lanes at once, only when every lane holds data. It extends the fixed output FIFO with:
- configurable depth;
- an occupancy count;
- an almost-full watermark;
- sticky overflow/underflow error flags;
- accepted push-on-full when a pop occurs in the same cycle.

## Interface
- `col`, 8, number of lanes (array columns)
- `bw`, 16, bits per lane entry
- `depth`, 64, entries per lane; power of two, ≥ 2
- `af_thresh`, 56, almost-full watermark in entries; 1..depth

- `clk`  in  1  rising-edge clock; one clock domain
- `reset`  in  1  synchronous, active-low reset; asserted when 0, sampled on `clk` rising edge
- `in`  in  col*bw  write data; lane i occupies bits [i*bw +: bw]
- `wr`  in  col  per-lane write strobe
- `rd`  in  1  pop-row request
- `clr_err`  in  1  clears `o_overflow` and `o_underflow`
- `out`  out  col*bw  registered popped row; lane i at [i*bw +: bw]
- `o_full`  out  1  at least one lane holds `depth` entries
- `o_ready`  out  1  equals `!o_full`
- `o_valid`  out  1  every lane holds ≥ 1 entry
- `o_almost_full`  out  1  at least one lane holds ≥ `af_thresh` entries
- `o_count`  out  $clog2(depth)+1  minimum lane occupancy (number of complete rows)
- `o_overflow`  out  1  sticky flag: a write was dropped
- `o_underflow`  out  1  sticky flag: a read was refused

## Operation
- Each lane is a circular buffer with `$clog2(depth)`-bit read and write pointers and a `$clog2(depth)+1`-bit count. Pointers wrap modulo `depth` with no special case.
- Pop: `pop = rd & o_valid`, evaluated on pre-edge state. On pop, every lane's read pointer advances, its count decrements, and `out` loads the head entry of every lane.
- Push, lane i: `push_i = wr[i] & (!full_i | pop)`. On push, the lane's write pointer advances and `in` lane i is stored.
  - A lane that is full accepts a write in the same cycle as a pop. Its count stays at `depth`.
- Dropped write: `wr[i] & full_i & !pop`. Storage and count are unchanged, and `o_overflow` is set.
- Refused read: `rd & !o_valid`. No state changes except `o_underflow`, which is set.
- Simultaneous push and pop on a lane leaves that lane's count unchanged.
- On an empty lane, a push in the same cycle as `rd` does not produce a pop, because `o_valid` is taken from pre-edge state.
- Error flags:
  - `clr_err` clears both flags.
  - Set takes priority over clear in the same cycle.
- Status outputs (`o_full`, `o_ready`, `o_valid`, `o_almost_full`, `o_count`) are combinational functions of the lane counts only. They have no path from `wr` or `rd`.

## Timing
- Reset (`reset`=0 at an edge) gives:
  - all pointers and counts = 0;
  - `out` = 0;
  - `o_full` = 0, `o_ready` = 1, `o_valid` = 0, `o_almost_full` = 0, `o_count` = 0;
  - `o_overflow` = 0, `o_underflow` = 0.
- A reset asserted mid-operation discards all contents at that edge. `wr` and `rd` are ignored in the reset cycle.
- Write to status: a write accepted at edge N is reflected in the status outputs after edge N. No bypass.
- Read latency is 1 cycle: `rd` sampled at edge N gives `out` valid after edge N. `out` holds its value until the next pop.
- Back-to-back pops are supported every cycle while `o_valid` stays 1. Sustained throughput is one row per cycle.

## Structure
- Shared package `ofifo_pkg` holds:
  - pointer/count width function `ptr_w(depth)`;
  - lane-slice helper constants.
  - The package is shared with the testbench.
- Sub-module `ofifo_lane` is one lane: `bw`-wide, `depth`-deep buffer with `push`, `pop`, `full`, `empty`, `count` and `dout`.
  - `ofifo_param` instantiates `col` lanes with a generate loop.
  - The top level holds the pop/push qualification, the min/max reductions, the error flags and the `out` register.

## Test plan
- **Reset defaults.** Reset at depth=64, then release. Required: `o_ready`=1, `o_valid`=0, `o_count`=0, `out`=0.
- **Staggered lanes.** Write lane 0 only, three times (`wr`=8'h01). Required: `o_valid`=0 and `o_count`=0. Then write the remaining lanes once with `wr`=8'hFE. Required: `o_valid`=1, `o_count`=1. `rd` then returns row 0 with lane 0 = its first write.
- **Fill and wrap.** Write 64 random rows. Required: `o_full`=1, with `o_almost_full` rising exactly at count 56. The 65th write is dropped and sets `o_overflow`=1. Read 64 rows: all match in order. Refill and drain 100 more rows to cross pointer wrap with no mismatch.
- **Push on full with pop.** When full, assert `wr`=8'hFF and `rd` together. Required: `o_count` stays 64, `o_overflow` stays 0, and the new row is returned last.
- **Underflow.** With the FIFO empty, assert `rd`. Required: `out` unchanged and `o_underflow`=1. Assert `clr_err`: flag returns to 0. Assert `clr_err` together with another refused `rd`: flag stays 1.
- **Reset mid-stream.** Reset after 10 writes and 3 reads. Required: all outputs return to reset values. The next write and read round-trips correctly.
